// File: rtl/seq_subtractor_pkg.sv
// Shared types and helpers for the sequential chunked subtractor.
package seq_sub_pkg;

  // Controller states: wait for operands, walk the chunks, hold the result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of a counter able to index n chunks; never narrower than one bit.
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/seq_subtractor_if.sv
// Operand/result bundle of the sequential subtractor.
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both high; the producer holds its payload stable while valid is high and
// ready is low, and valid never waits on ready.
interface seq_subtractor_if #(
  parameter int WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             zero;
  logic             ovf;

  // Producer of operands / consumer of results.
  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, zero, ovf
  );

  // The subtractor itself.
  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, zero, ovf
  );
endinterface

// File: rtl/seq_subtractor_sub_chunk.sv
// Combinational W-bit subtract with borrow in and borrow out.
module sub_chunk #(
  parameter int W = 8
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         bi,
  output logic [W-1:0] d,
  output logic         bo
);
  logic [W:0] w_full;

  // One extra bit catches the borrow: a negative result sets the top bit.
  assign w_full = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bi};
  assign d      = w_full[W-1:0];
  assign bo     = w_full[W];
endmodule

// File: rtl/seq_subtractor.sv
// Multi-cycle WIDTH-bit subtractor: CHUNK bits per clock, running borrow kept
// in a register, borrow-out / zero / signed-overflow flags on completion.
module seq_subtractor
  import seq_sub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic              clk,
  input  logic              rst,
  seq_subtractor_if.slave   bus,
  output state_t            dbg_state
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = cnt_width(NCHUNK);

  generate
    if (WIDTH < 1 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
      $error("seq_subtractor: CHUNK must divide WIDTH and lie in 1..WIDTH");
    end
  endgenerate

  state_t           r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_zero;
  logic             r_ovf;
  logic             r_borrow;
  logic             r_zacc;
  logic [CW-1:0]    r_cnt;

  logic [CHUNK-1:0] w_x;
  logic [CHUNK-1:0] w_y;
  logic [CHUNK-1:0] w_d;
  logic             w_bo;
  logic             w_last;
  logic             w_chunk_zero;

  // Select the operand chunks addressed by the chunk counter.
  always_comb begin
    w_x = '0;
    w_y = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (r_cnt == CW'(i)) begin
        w_x = r_a[i*CHUNK +: CHUNK];
        w_y = r_b[i*CHUNK +: CHUNK];
      end
    end
  end

  assign w_last       = (r_cnt == CW'(NCHUNK - 1));
  assign w_chunk_zero = (w_d == '0);

  sub_chunk #(.W(CHUNK)) u_chunk (
    .x  (w_x),
    .y  (w_y),
    .bi (r_borrow),
    .d  (w_d),
    .bo (w_bo)
  );

  // Controller and result registers; every output is registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_diff      <= '0;
      r_bout      <= 1'b0;
      r_zero      <= 1'b0;
      r_ovf       <= 1'b0;
      r_borrow    <= 1'b0;
      r_zacc      <= 1'b0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid && r_in_ready) begin
            r_a        <= bus.a;
            r_b        <= bus.b;
            r_borrow   <= bus.bin;
            r_cnt      <= '0;
            r_zacc     <= 1'b1;
            r_in_ready <= 1'b0;
            r_state    <= RUN;
          end
        end
        RUN: begin
          for (int i = 0; i < NCHUNK; i++) begin
            if (r_cnt == CW'(i)) r_diff[i*CHUNK +: CHUNK] <= w_d;
          end
          r_borrow <= w_bo;
          r_zacc   <= r_zacc & w_chunk_zero;
          r_cnt    <= r_cnt + CW'(1);
          if (w_last) begin
            // The top chunk is being produced now, so its MSB is the diff MSB.
            r_bout      <= w_bo;
            r_zero      <= r_zacc & w_chunk_zero;
            r_ovf       <= (r_a[WIDTH-1] ^ r_b[WIDTH-1]) & (w_d[CHUNK-1] ^ r_a[WIDTH-1]);
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.diff      = r_diff;
  assign bus.bout      = r_bout;
  assign bus.zero      = r_zero;
  assign bus.ovf       = r_ovf;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_seq_subtractor.sv
// Directed bench: WIDTH=8/CHUNK=4 main instance plus a WIDTH=CHUNK=8 instance.
module tb_seq_subtractor;
  import seq_sub_pkg::*;

  logic   clk;
  logic   rst;
  state_t st4;
  state_t st8;
  int     n_checks;
  int     n_errors;

  seq_subtractor_if #(.WIDTH(8)) bus4 ();
  seq_subtractor_if #(.WIDTH(8)) bus8 ();

  seq_subtractor #(.WIDTH(8), .CHUNK(4)) u_dut4 (
    .clk (clk), .rst (rst), .bus (bus4), .dbg_state (st4)
  );

  seq_subtractor #(.WIDTH(8), .CHUNK(8)) u_dut8 (
    .clk (clk), .rst (rst), .bus (bus8), .dbg_state (st8)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- drivers (main instance) ----------------
  task automatic send4(input logic [7:0] a, input logic [7:0] b, input logic bin);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus4.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("in_ready_timeout", 32'd0, 32'd1);
    bus4.a = a; bus4.b = b; bus4.bin = bin; bus4.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus4.in_valid = 1'b0;
    bus4.a = ~a; bus4.b = ~b; bus4.bin = ~bin;
  endtask

  task automatic wait_out4(output int lat);
    lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      lat++;
      #1;
      if (bus4.out_valid) break;
    end
  endtask

  task automatic release4;
    bus4.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus4.out_ready = 1'b0;
  endtask

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] d;
    logic       bo;
    logic       z;
    logic       ov;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int lat;
    int seen;
    n_checks = 0;
    n_errors = 0;

    // a, b, bin, diff, bout, zero, ovf -- worked by hand
    vecs[0] = '{8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'h10, 8'h01, 1'b1, 8'h0E, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{8'h05, 8'h05, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{8'h04, 8'h04, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};

    bus4.in_valid = 1'b0; bus4.out_ready = 1'b0;
    bus4.a = '0; bus4.b = '0; bus4.bin = 1'b0;
    bus8.in_valid = 1'b0; bus8.out_ready = 1'b0;
    bus8.a = '0; bus8.b = '0; bus8.bin = 1'b0;

    // ---------------- power-on reset ----------------
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("por_in_ready",  32'(bus4.in_ready), 32'd1);
    check("por_out_valid", 32'(bus4.out_valid), 32'd0);
    check("por_diff",      32'(bus4.diff), 32'd0);
    check("por_flags",     {29'd0, bus4.bout, bus4.zero, bus4.ovf}, 32'd0);
    check("por_state",     32'(st4), 32'(IDLE));
    check("por8_in_ready", 32'(bus8.in_ready), 32'd1);

    // ---------------- directed vectors ----------------
    for (int i = 0; i < 8; i++) begin
      send4(vecs[i].a, vecs[i].b, vecs[i].bin);
      wait_out4(lat);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'd2);
      check($sformatf("v%0d_diff", i), 32'(bus4.diff), 32'(vecs[i].d));
      check($sformatf("v%0d_bout", i), 32'(bus4.bout), 32'(vecs[i].bo));
      check($sformatf("v%0d_zero", i), 32'(bus4.zero), 32'(vecs[i].z));
      check($sformatf("v%0d_ovf", i), 32'(bus4.ovf), 32'(vecs[i].ov));
      release4();
    end

    // ---------------- backpressure ----------------
    send4(8'h80, 8'h01, 1'b0);
    wait_out4(lat);
    check("bp_latency", 32'(lat), 32'd2);
    for (int c = 0; c < 5; c++) begin
      if (c == 1) begin
        bus4.a = 8'hAA; bus4.b = 8'h00; bus4.bin = 1'b0; bus4.in_valid = 1'b1;
      end else begin
        bus4.in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      check($sformatf("bp%0d_valid", c), 32'(bus4.out_valid), 32'd1);
      check($sformatf("bp%0d_diff", c),  32'(bus4.diff), 32'h7F);
      check($sformatf("bp%0d_flags", c), {29'd0, bus4.bout, bus4.zero, bus4.ovf}, 32'b001);
      check($sformatf("bp%0d_in_ready", c), 32'(bus4.in_ready), 32'd0);
      check($sformatf("bp%0d_state", c), 32'(st4), 32'(DONE));
    end
    bus4.in_valid = 1'b0;
    release4();
    check("bp_rel_state", 32'(st4), 32'(IDLE));
    check("bp_rel_valid", 32'(bus4.out_valid), 32'd0);
    check("bp_rel_in_ready", 32'(bus4.in_ready), 32'd1);
    check("bp_diff_held", 32'(bus4.diff), 32'h7F);
    send4(8'hAA, 8'h55, 1'b0);
    wait_out4(lat);
    check("aa55_latency", 32'(lat), 32'd2);
    check("aa55_diff", 32'(bus4.diff), 32'h55);
    check("aa55_ovf",  32'(bus4.ovf), 32'd1);
    release4();

    // ---------------- reset one cycle after acceptance ----------------
    send4(8'h35, 8'h12, 1'b0);
    check("rr_state_run", 32'(st4), 32'(RUN));
    rst = 1'b1;
    #1;
    check("rr_async_state", 32'(st4), 32'(IDLE));
    seen = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (bus4.out_valid) seen++;
    end
    rst = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (bus4.out_valid) seen++;
    end
    check("rr_no_out_valid", 32'(seen), 32'd0);
    check("rr_state", 32'(st4), 32'(IDLE));
    check("rr_in_ready", 32'(bus4.in_ready), 32'd1);
    check("rr_diff", 32'(bus4.diff), 32'd0);
    check("rr_flags", {29'd0, bus4.bout, bus4.zero, bus4.ovf}, 32'd0);

    // ---------------- reset while holding a result ----------------
    send4(8'h80, 8'h01, 1'b0);
    wait_out4(lat);
    check("rd_latency", 32'(lat), 32'd2);
    rst = 1'b1;
    #1;
    check("rd_valid", 32'(bus4.out_valid), 32'd0);
    check("rd_diff", 32'(bus4.diff), 32'd0);
    check("rd_ovf", 32'(bus4.ovf), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    check("rd_in_ready", 32'(bus4.in_ready), 32'd1);

    // ---------------- single-chunk build ----------------
    @(negedge clk);
    bus8.a = 8'h00; bus8.b = 8'hFF; bus8.bin = 1'b1; bus8.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus8.in_valid = 1'b0; bus8.a = 8'h5A; bus8.b = 8'h11; bus8.bin = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      lat++;
      #1;
      if (bus8.out_valid) break;
    end
    check("w8_latency", 32'(lat), 32'd1);
    check("w8_diff", 32'(bus8.diff), 32'h00);
    check("w8_bout", 32'(bus8.bout), 32'd1);
    check("w8_zero", 32'(bus8.zero), 32'd1);
    check("w8_ovf",  32'(bus8.ovf), 32'd0);
    bus8.out_ready = 1'b1;
    @(posedge clk);
    #1 bus8.out_ready = 1'b0;
    check("w8_state", 32'(st8), 32'(IDLE));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
